// File: rtl/mux8_rr_arbiter_pkg.sv
// rtl/mux8_rr_arbiter_pkg.sv - shared constants and FSM encoding for the round-robin mux arbiter
package mux8_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// rtl/mux8_rr_arbiter_rr_pick.sv - combinational first-set search starting at a rotating index
module rr_pick
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk start, start+1, ... (mod 8) and keep the first set bit encountered
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = start + SEL_W'(k);
      if (mask[cand] && !found) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter owning the select of an 8:1 single-bit mux
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             lock,
  input  logic [N_REQ-1:0] Input,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             Out
);

  // Last hold count an owner may reach before it yields to a waiting contender.
  // Compared with >= so an owner that ran past the limit under lock yields as
  // soon as lock drops.
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [CNT_W-1:0] HOLD_SAT  = '1;

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [SEL_W-1:0] sel_n;
  logic [CNT_W-1:0] hold_cnt, hold_n;
  logic [N_REQ-1:0] gnt_n;
  logic             valid_n;

  logic [N_REQ-1:0] others;
  logic [N_REQ-1:0] pick_mask;
  logic [SEL_W-1:0] pick_start;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             preempt;
  logic             mux_out;

  // While granted the owner is excluded and the search starts just after it
  assign others     = req & ~gnt;
  assign pick_mask  = (state == GRANT) ? others : req;
  assign pick_start = (state == GRANT) ? sel + SEL_W'(1) : ptr;

  rr_pick u_pick (
    .mask  (pick_mask),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign preempt = (MAX_HOLD != 0) && req[sel] && (hold_cnt >= HOLD_LAST)
                   && !lock && (|others);

  // Next-state: grant from idle, release/preempt hand-off without a bubble, or keep owner
  always_comb begin
    state_n = state;
    sel_n   = sel;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = GRANT;
          sel_n   = pick_idx;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (!req[sel] || preempt) begin
          ptr_n  = sel + SEL_W'(1);
          hold_n = '0;
          if (pick_found) begin
            sel_n = pick_idx;
          end else begin
            state_n = IDLE;
            sel_n   = '0;
          end
        end else if (hold_cnt != HOLD_SAT) begin
          hold_n = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        sel_n   = '0;
        hold_n  = '0;
      end
    endcase
    valid_n = (state_n == GRANT);
    gnt_n   = valid_n ? (N_REQ'(1) << sel_n) : '0;
  end

  // Grant, select and valid are registered together so they always move on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      valid    <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      valid    <= valid_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  assign mux_out = Input[sel];
  assign Out     = valid & mux_out;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - scoreboard bench for the round-robin mux arbiter
module tb_mux8_rr_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       lock;
  logic [7:0] din;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic       dout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    logic       o;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  int m_owner;
  int m_ptr;
  int m_hold;

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .Input (din),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .Out   (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick_from(input logic [7:0] mask, input int start);
    for (int k = 0; k < 8; k++) begin
      if (mask[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r_rst, input logic [7:0] r, input logic l);
    logic [7:0] oth;
    if (r_rst) begin
      m_owner = -1; m_ptr = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      m_owner = pick_from(r, m_ptr);
      m_hold  = 0;
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (!r[m_owner] ||
          (m_hold >= MAX_HOLD - 1 && !l && oth != 8'h00)) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = pick_from(oth, m_ptr);
        m_hold  = 0;
      end else if (m_hold < (1 << CNT_W) - 1) begin
        m_hold++;
      end
    end
  endtask

  // one clock: drive on falling edge, predict, then compare just after the rising edge
  task automatic step(input logic r_rst, input logic [7:0] r, input logic l, input logic [7:0] d);
    exp_t e, got;
    @(negedge clk);
    reset = r_rst; req = r; lock = l; din = d;
    model_step(r_rst, r, l);
    e.v = (m_owner >= 0);
    e.s = e.v ? 3'(m_owner) : 3'd0;
    e.g = e.v ? (8'h01 << m_owner) : 8'h00;
    e.o = e.v ? d[e.s] : 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("sb_gnt",   gnt,          got.g);
    check("sb_sel",   {5'd0, sel},  {5'd0, got.s});
    check("sb_valid", {7'd0, valid},{7'd0, got.v});
    check("sb_out",   {7'd0, dout}, {7'd0, got.o});
  endtask

  initial begin
    logic seen;
    logic       rr;
    logic [7:0] rq;
    reset = 1'b1; req = 8'h00; lock = 1'b0; din = 8'h00;
    m_owner = -1; m_ptr = 0; m_hold = 0;

    // reset with everyone requesting
    step(1'b1, 8'hFF, 1'b0, 8'hFF);
    step(1'b1, 8'hFF, 1'b0, 8'hFF);
    check("rst_gnt", gnt, 8'h00);
    check("rst_sel", {5'd0, sel}, 8'h00);
    check("rst_out", {7'd0, dout}, 8'h00);

    // idle, then a single requester
    step(1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b0, 8'h10, 1'b0, 8'h00);
    check("single_gnt", gnt, 8'h10);
    check("single_sel", {5'd0, sel}, 8'h04);
    step(1'b0, 8'h10, 1'b0, 8'h10);
    check("single_out", {7'd0, dout}, 8'h01);
    step(1'b0, 8'h00, 1'b0, 8'h10);

    // full contention: 0..7,0 each for exactly MAX_HOLD cycles
    step(1'b1, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 9 * MAX_HOLD; i++) begin
      step(1'b0, 8'hFF, 1'b0, 8'hA5);
      check("rr_sel", {5'd0, sel}, 8'((i / MAX_HOLD) % 8));
    end

    // wrap from owner 7 to requester 0, then idle
    step(1'b1, 8'h00, 1'b0, 8'h00);
    step(1'b0, 8'h80, 1'b0, 8'h00);
    check("wrap_own7", gnt, 8'h80);
    step(1'b0, 8'h01, 1'b0, 8'h00);
    check("wrap_gnt", gnt, 8'h01);
    step(1'b0, 8'h00, 1'b0, 8'h00);
    check("wrap_idle", gnt, 8'h00);

    // lock holds owner 2 past the limit, dropping lock hands over to 3
    step(1'b1, 8'h00, 1'b0, 8'h00);
    step(1'b0, 8'h04, 1'b1, 8'h00);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'h0C, 1'b1, 8'h0C);
      check("lock_hold", gnt, 8'h04);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h0C, 1'b0, 8'h0C);
      if (gnt == 8'h08) seen = 1'b1;
    end
    check("lock_release", {7'd0, seen}, 8'h01);

    // reset mid-tenure, then pointer back at 0
    step(1'b1, 8'h00, 1'b0, 8'h00);
    step(1'b0, 8'h20, 1'b0, 8'h00);
    check("mid_own5", gnt, 8'h20);
    step(1'b1, 8'h20, 1'b0, 8'h00);
    check("mid_rst", gnt, 8'h00);
    step(1'b0, 8'h21, 1'b0, 8'h00);
    check("mid_ptr0", gnt, 8'h01);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 39) == 0);
      rq = 8'($urandom) & 8'($urandom);
      step(rr, rq, ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1);
  end

endmodule
